// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forward-mux selects, result-source selects,
// supervisor FSM states, and the per-operand forwarding priority function.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MALU = 2'b10,
    FWD_MIMM = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HELD = 2'b01,
    ST_ERR  = 2'b10
  } hazard_state_e;

  // M has priority over W; M only forwards values already known (ALU or imm),
  // a load or PC+4 in M falls through to the W check.
  function automatic fwd_sel_e fwdSelect(
    input logic [4:0] rs,
    input logic [4:0] rdM,
    input logic       regWriteM,
    input logic [1:0] resultSrcM,
    input logic [4:0] rdW,
    input logic       regWriteW
  );
    logic mHit;
    logic wHit;
    mHit = regWriteM && (rdM != 5'd0) && (rdM == rs);
    wHit = regWriteW && (rdW != 5'd0) && (rdW == rs);
    if (mHit && resultSrcM == RES_ALU) return FWD_MALU;
    if (mHit && resultSrcM == RES_IMM) return FWD_MIMM;
    if (wHit) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module hazard_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: combinational stall/flush/forward control, performance
// counters, and a sticky flag raised when the fetch stage is held two cycles in a row.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       PCSrcE,
  input  logic             ResultSrcE0,
  input  logic [1:0]       ResultSrcM,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             perf_clr,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] fwd_cnt,
  output logic             hazard_err,
  output hazard_state_e    dbgState
);

  logic lwStall;
  logic redirect;
  logic fwdActive;
  hazard_state_e state;

  assign lwStall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign redirect = (PCSrcE != 2'b00);

  // A taken redirect squashes the load-use bubble, so it also cancels the stall.
  assign FlushD = redirect;
  assign FlushE = redirect || lwStall;
  assign StallF = lwStall && !redirect;
  assign StallD = StallF;

  assign ForwardAE = fwdSelect(Rs1E, RdM, RegWriteM, ResultSrcM, RdW, RegWriteW);
  assign ForwardBE = fwdSelect(Rs2E, RdM, RegWriteM, ResultSrcM, RdW, RegWriteW);
  assign fwdActive = (ForwardAE != FWD_REG) || (ForwardBE != FWD_REG);

  // hazard_err trails the ERR state by one edge and is cleared together with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      hazard_err <= 1'b0;
    end else if (perf_clr) begin
      state      <= ST_RUN;
      hazard_err <= 1'b0;
    end else begin
      hazard_err <= (state == ST_ERR);
      case (state)
        ST_RUN:  if (StallF) state <= ST_HELD;
        ST_HELD: state <= StallF ? ST_ERR : ST_RUN;
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_RUN;
      endcase
    end
  end

  assign dbgState = state;

  hazard_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk(clk), .rst(rst), .inc(StallF), .clr(perf_clr), .count(stall_cnt)
  );

  hazard_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk(clk), .rst(rst), .inc(FlushD), .clr(perf_clr), .count(flush_cnt)
  );

  hazard_counter #(.CNT_W(CNT_W)) uFwdCnt (
    .clk(clk), .rst(rst), .inc(fwdActive), .clr(perf_clr), .count(fwd_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: constant vector table, hand-written multi-cycle sequences,
// and random stimulus against a counting reference model (32-bit and 4-bit instances).
module tb_hazard_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] PCSrcE, ResultSrcM;
  logic ResultSrcE0, RegWriteM, RegWriteW, perf_clr;

  logic StallF, StallD, FlushD, FlushE, hazard_err;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] stall_cnt, flush_cnt, fwd_cnt;
  hazard_state_e dbgState;

  logic StallF4, StallD4, FlushD4, FlushE4, hazardErr4;
  logic [1:0] ForwardAE4, ForwardBE4;
  logic [3:0] stallCnt4, flushCnt4, fwdCnt4;
  hazard_state_e dbgState4;

  int total = 0;
  int bad = 0;

  // reference model state: unbounded event counts and consecutive-stall tracking
  longint mStall, mFlush, mFwd;
  int runLen;
  bit errLatched, errOut;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE), .ResultSrcE0(ResultSrcE0),
    .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .perf_clr(perf_clr), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fwd_cnt(fwd_cnt),
    .hazard_err(hazard_err), .dbgState(dbgState)
  );

  hazard_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE), .ResultSrcE0(ResultSrcE0),
    .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .perf_clr(perf_clr), .StallF(StallF4), .StallD(StallD4), .FlushD(FlushD4),
    .FlushE(FlushE4), .ForwardAE(ForwardAE4), .ForwardBE(ForwardBE4),
    .stall_cnt(stallCnt4), .flush_cnt(flushCnt4), .fwd_cnt(fwdCnt4),
    .hazard_err(hazardErr4), .dbgState(dbgState4)
  );

  typedef struct {
    logic [4:0] rs1D, rs2D, rdE, rs1E, rs2E, rdM, rdW;
    logic       resE0, regWM, regWW;
    logic [1:0] pc, resM;
    logic [3:0] expCtl;  // {StallF, StallD, FlushD, FlushE}
    logic [1:0] expA, expB;
    string      name;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(
    input logic [4:0] rs1D, rs2D, rdE, input logic resE0, input logic [1:0] pc,
    input logic [4:0] rs1E, rs2E, rdM, input logic regWM, input logic [1:0] resM,
    input logic [4:0] rdW, input logic regWW,
    input logic [3:0] expCtl, input logic [1:0] expA, expB, input string name);
    vec_t v;
    v.rs1D = rs1D; v.rs2D = rs2D; v.rdE = rdE; v.resE0 = resE0; v.pc = pc;
    v.rs1E = rs1E; v.rs2E = rs2E; v.rdM = rdM; v.regWM = regWM; v.resM = resM;
    v.rdW = rdW; v.regWW = regWW; v.expCtl = expCtl; v.expA = expA; v.expB = expB;
    v.name = name;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    PCSrcE = 0; ResultSrcM = 0; ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0;
    perf_clr = 0;
  endtask

  task automatic loadStall();
    idle();
    RdE = 5'd5; ResultSrcE0 = 1'b1; Rs1D = 5'd5;
  endtask

  function automatic int refFwd(input logic [4:0] rs);
    bit mMatch, wMatch;
    mMatch = RegWriteM && RdM != 0 && RdM == rs;
    wMatch = RegWriteW && RdW != 0 && RdW == rs;
    if (mMatch && ResultSrcM == 2'b00) return 2;
    if (mMatch && ResultSrcM == 2'b11) return 3;
    if (wMatch) return 1;
    return 0;
  endfunction

  function automatic longint sat4(input longint c);
    return (c > 15) ? 15 : c;
  endfunction

  task automatic modelReset();
    mStall = 0; mFlush = 0; mFwd = 0; runLen = 0; errLatched = 0; errOut = 0;
  endtask

  task automatic checkRegs(input string tag);
    chk({tag, ".stall_cnt"}, stall_cnt, mStall);
    chk({tag, ".flush_cnt"}, flush_cnt, mFlush);
    chk({tag, ".fwd_cnt"}, fwd_cnt, mFwd);
    chk({tag, ".hazard_err"}, hazard_err, errOut);
    chk({tag, ".stall_cnt4"}, stallCnt4, sat4(mStall));
    chk({tag, ".flush_cnt4"}, flushCnt4, sat4(mFlush));
    chk({tag, ".fwd_cnt4"}, fwdCnt4, sat4(mFwd));
    chk({tag, ".hazard_err4"}, hazardErr4, errOut);
  endtask

  // Inputs are already applied (posedge+1); check combinational outputs at the
  // falling edge, advance the model on the rising edge, then check registers.
  task automatic step(input string tag);
    bit lw, redir, eStall;
    int fa, fb;
    #4;
    lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    redir = PCSrcE != 0;
    eStall = lw && !redir;
    fa = refFwd(Rs1E);
    fb = refFwd(Rs2E);
    chk({tag, ".StallF"}, StallF, eStall);
    chk({tag, ".StallD"}, StallD, eStall);
    chk({tag, ".FlushD"}, FlushD, redir);
    chk({tag, ".FlushE"}, FlushE, redir || lw);
    chk({tag, ".ForwardAE"}, ForwardAE, fa);
    chk({tag, ".ForwardBE"}, ForwardBE, fb);
    @(posedge clk);
    if (perf_clr) begin
      modelReset();
    end else begin
      if (eStall) mStall++;
      if (redir) mFlush++;
      if (fa != 0 || fb != 0) mFwd++;
      errOut = errLatched;
      runLen = eStall ? runLen + 1 : 0;
      if (runLen >= 2) errLatched = 1;
    end
    #1;
    checkRegs(tag);
  endtask

  initial begin
    idle();
    modelReset();
    // rs1D rs2D rdE e0 pc  rs1E rs2E rdM wM resM rdW wW ctl     A      B
    vecs[0]  = mk(5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1101, 2'b00, 2'b00, "ld_use_rs1");
    vecs[1]  = mk(1, 9, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1101, 2'b00, 2'b00, "ld_use_rs2");
    vecs[2]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, "ld_rd_zero");
    vecs[3]  = mk(5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, "no_load");
    vecs[4]  = mk(0, 0, 0, 0, 0, 7, 0, 7, 1, 0, 7, 1, 4'b0000, 2'b10, 2'b00, "fwd_m_alu");
    vecs[5]  = mk(0, 0, 0, 0, 0, 7, 0, 7, 1, 3, 7, 1, 4'b0000, 2'b11, 2'b00, "fwd_m_imm");
    vecs[6]  = mk(0, 0, 0, 0, 0, 7, 0, 7, 1, 1, 7, 1, 4'b0000, 2'b01, 2'b00, "fwd_m_load_w");
    vecs[7]  = mk(0, 0, 0, 0, 0, 7, 0, 7, 1, 2, 7, 1, 4'b0000, 2'b01, 2'b00, "fwd_m_pc4_w");
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 4'b0000, 2'b00, 2'b00, "fwd_x0");
    vecs[9]  = mk(5, 0, 5, 1, 2, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 2'b00, 2'b00, "redir_over_stall");
    vecs[10] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 2'b00, 2'b00, "redir_only");
    vecs[11] = mk(0, 0, 0, 0, 0, 4, 3, 4, 1, 0, 3, 1, 4'b0000, 2'b10, 2'b01, "fwd_a_m_b_w");
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 6, 0, 4'b0000, 2'b00, 2'b00, "w_no_write");

    // Combinational table applied while reset holds the registered state at zero.
    for (int i = 0; i < 13; i++) begin
      Rs1D = vecs[i].rs1D; Rs2D = vecs[i].rs2D; RdE = vecs[i].rdE;
      ResultSrcE0 = vecs[i].resE0; PCSrcE = vecs[i].pc; Rs1E = vecs[i].rs1E;
      Rs2E = vecs[i].rs2E; RdM = vecs[i].rdM; RegWriteM = vecs[i].regWM;
      ResultSrcM = vecs[i].resM; RdW = vecs[i].rdW; RegWriteW = vecs[i].regWW;
      #3;
      chk({vecs[i].name, ".ctl"}, {StallF, StallD, FlushD, FlushE}, vecs[i].expCtl);
      chk({vecs[i].name, ".ForwardAE"}, ForwardAE, vecs[i].expA);
      chk({vecs[i].name, ".ForwardBE"}, ForwardBE, vecs[i].expB);
      chk({vecs[i].name, ".rst_cnt"}, stall_cnt | flush_cnt | fwd_cnt, 0);
      chk({vecs[i].name, ".rst_err"}, hazard_err, 0);
      #7;
    end

    // Load-use stall on the first edge after reset release is counted.
    @(posedge clk); #1;
    rst = 0;
    modelReset();
    loadStall();
    step("first_stall");
    chk("first_stall.cnt_is_1", stall_cnt, 1);

    // Second consecutive stall, then an idle cycle: error appears on the third edge.
    step("stall2");
    chk("stall2.err_still_0", hazard_err, 0);
    idle();
    step("edge3");
    chk("edge3.err_set", hazard_err, 1);
    step("sticky");
    chk("sticky.err_held", hazard_err, 1);

    // Redirect with a simultaneous load-use hazard.
    loadStall();
    PCSrcE = 2'b10;
    step("redir_stall");
    chk("redir_stall.flush_cnt", flush_cnt, 1);

    // perf_clr wins over increments in the same cycle.
    loadStall();
    perf_clr = 1;
    step("perf_clr");
    chk("perf_clr.err", hazard_err, 0);
    chk("perf_clr.stall_cnt", stall_cnt, 0);

    // 20 stall cycles saturate the 4-bit counter.
    loadStall();
    for (int i = 0; i < 20; i++) step("sat_run");
    chk("sat_run.cnt4_is_15", stallCnt4, 15);
    chk("sat_run.cnt32_is_20", stall_cnt, 20);

    // Asynchronous reset mid-cycle clears counters without a clock edge.
    #3;
    rst = 1;
    #1;
    chk("async_rst.stall_cnt", stall_cnt, 0);
    chk("async_rst.stall_cnt4", stallCnt4, 0);
    chk("async_rst.err", hazard_err, 0);
    @(posedge clk); #1;
    rst = 0;
    modelReset();

    // Random traffic with register numbers drawn from a small set to provoke matches.
    for (int i = 0; i < 400; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3));
      RdW = 5'($urandom_range(0, 3));
      PCSrcE = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ResultSrcE0 = 1'($urandom_range(0, 1));
      ResultSrcM = 2'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      perf_clr = ($urandom_range(0, 19) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of each performance counter.
REQ-002 SHALL have port clk  in  1: single clock, rising edge.
REQ-003 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-004 SHALL have ports Rs1D, Rs2D  in  5 each: decode-stage source registers.
REQ-005 SHALL have ports Rs1E, Rs2E, RdE  in  5 each: execute-stage sources and destination.
REQ-006 SHALL have ports RdM, RdW  in  5 each: memory- and writeback-stage destinations.
REQ-007 SHALL have port PCSrcE  in  2: execute redirect select; nonzero means taken.
REQ-008 SHALL have port ResultSrcE0  in  1: execute result comes from memory or immediate.
REQ-009 SHALL have port ResultSrcM  in  2: memory-stage result select (00 ALU, 01 load, 10 PC+4, 11 imm).
REQ-010 SHALL have ports RegWriteM, RegWriteW  in  1 each: stage write enables.
REQ-011 SHALL have port perf_clr  in  1: synchronous clear of counters and error flag.
REQ-012 SHALL have ports StallF, StallD, FlushD, FlushE  out  1 each: pipeline control.
REQ-013 SHALL have ports ForwardAE, ForwardBE  out  2 each: operand mux select (00 reg, 01 W result, 10 M ALU, 11 M imm).
REQ-014 SHALL have ports stall_cnt, flush_cnt, fwd_cnt  out  CNT_W each: performance counters.
REQ-015 SHALL have port hazard_err  out  1: sticky protocol-violation flag.

Function
REQ-016 SHALL compute lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D), combinationally.
REQ-017 SHALL drive redirect = (PCSrcE != 00); FlushD = redirect; FlushE = redirect | lwStall.
REQ-018 SHALL drive StallF = StallD = lwStall & ~redirect; a taken redirect overrides the stall.
REQ-019 SHALL select ForwardAE per Rs1E: if RegWriteM, RdM!=0, RdM==Rs1E and ResultSrcM==00 -> 10; else if the same match holds and ResultSrcM==11 -> 11; else if RegWriteW, RdW!=0, RdW==Rs1E -> 01; else 00.
REQ-020 SHALL select ForwardBE identically using Rs2E; the M stage has priority over the W stage.
REQ-021 SHALL never forward from M when ResultSrcM is 01 or 10; it SHALL fall through to the W check.
REQ-022 SHALL implement an FSM with states RUN, HELD, and ERR; reset state RUN.
REQ-023 SHALL transition RUN->HELD when StallF=1; HELD->RUN when StallF=0; HELD->ERR when StallF=1 (consecutive stall cycles); ERR is held until rst or perf_clr returns it to RUN.
REQ-024 SHALL drive hazard_err = (state==ERR), registered.
REQ-025 SHALL increment stall_cnt each cycle StallF=1, flush_cnt each cycle FlushD=1, and fwd_cnt each cycle (ForwardAE!=00 | ForwardBE!=00), at most +1 per counter per cycle.
REQ-026 SHALL saturate each counter at all-ones with no wrap.
REQ-027 SHALL give perf_clr priority over increments in the same cycle: counters become 0 and the FSM goes to RUN; the combinational outputs are unaffected.
REQ-028 SHALL keep pipeline-control outputs purely combinational, with 0-cycle latency; counters update 1 cycle later.

Reset
REQ-029 SHALL, while rst=1, asynchronously force counters to 0, hazard_err=0, FSM=RUN; combinational outputs keep following their inputs.
REQ-030 SHALL lose no increment on the first clock edge after rst deasserts.

Structure
REQ-031 SHALL take ForwardAE/ForwardBE encodings, ResultSrc encodings, and FSM state encodings from a shared package, e.g. hazard_pkg.
REQ-032 SHALL instantiate one sub-module, hazard_counter (CNT_W, inc, clr, saturating), three times.

Verification
REQ-033 SHALL verify: RdE=5, ResultSrcE0=1, Rs1D=5, PCSrcE=00 -> StallF=StallD=FlushE=1, FlushD=0; stall_cnt=1 next cycle.
REQ-034 SHALL verify: RegWriteM=1, RdM=7, ResultSrcM=00, RegWriteW=1, RdW=7, Rs1E=7 -> ForwardAE=10; with ResultSrcM=11 -> 11; with ResultSrcM=01 -> 01.
REQ-035 SHALL verify: RdM=0, RegWriteM=1, Rs2E=0 -> ForwardBE=00.
REQ-036 SHALL verify: PCSrcE=10 with a simultaneous lwStall -> FlushD=FlushE=1, StallF=StallD=0; flush_cnt increments.
REQ-037 SHALL verify: StallF forced high for 2 consecutive cycles -> hazard_err=1 from the 3rd edge, sticky; perf_clr -> hazard_err=0 and counters=0.
REQ-038 SHALL verify: CNT_W=4 with 20 stall cycles -> stall_cnt=15; rst mid-run -> all counters 0 immediately.
